// File: rtl/gol_input_ctrl.sv
// -----------------------------------------------------------------------------
// gol_input_ctrl
//
// Front end of the Game of Life controller. Every raw push-button passes
// through a two-flop synchroniser, a counter debounce and a rising-edge
// detector. The clean edges become commands:
//   [0] run/pause  -> toggles the latched running level
//   [1] randomise  -> rnd_req, held until rnd_ack
//   [2] step       -> upd_req (only while paused), held until upd_ack
//
// Optional build macro: GOL_INPUT_AUTOREPEAT_EN
//   When defined, holding step while paused re-fires a step request
//   REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn_in     in   [2:0] raw asynchronous buttons
//   upd_ack    in   downstream accepted the step request
//   rnd_ack    in   downstream accepted the randomise request
//   running    out  1 = free-run, 0 = paused (1 after reset)
//   upd_req    out  single-step request
//   rnd_req    out  randomise request
//   btn_level  out  [2:0] debounced button levels
// -----------------------------------------------------------------------------
module gol_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned REPEAT_DELAY    = 12000000,
  parameter int unsigned REPEAT_PERIOD   = 2400000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_in,
  input  logic       upd_ack,
  input  logic       rnd_ack,
  output logic       running,
  output logic       upd_req,
  output logic       rnd_req,
  output logic [2:0] btn_level
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject out-of-range configurations at elaboration.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W - 1) ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > (2**CNT_W - 1) ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > (2**CNT_W - 1)) begin : g_bad_param
    $error("gol_input_ctrl: parameter out of legal range");
  end

  logic [2:0]       r_s1;
  logic [2:0]       r_s2;
  logic [2:0]       r_stable;
  logic [2:0]       r_stable_d;
  logic [CNT_W-1:0] r_cnt [3];
  logic             r_running;
  logic             r_upd_req;
  logic             r_rnd_req;

  logic [2:0]       w_rise;
  logic             w_rep_evt;
  logic             w_step_evt;

  // Synchroniser and per-bit debounce.
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  // NOTE: the debounce counters are a small flop array, not RAM, so they are
  // reset along with everything else; no memory macro is implied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1       <= btn_in;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle pulse in the cycle the debounced level is first seen high.
  assign w_rise = r_stable & ~r_stable_d;

`ifdef GOL_INPUT_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_PERIOD = CNT_W'(REPEAT_PERIOD);

  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_rep_first;   // still waiting for the initial delay
  logic             w_rep_hold;

  assign w_rep_hold = r_stable[2] & ~r_running;

  // Counter value k means k cycles since the press (or since last repeat);
  // zero means idle.
  assign w_rep_evt = w_rep_hold && (r_rep_cnt != '0) &&
                     (r_rep_first ? (r_rep_cnt == REP_DELAY)
                                  : (r_rep_cnt == REP_PERIOD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (!w_rep_hold) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (w_rise[2]) begin
      r_rep_cnt   <= CNT_W'(1);
      r_rep_first <= 1'b1;
    end else if (w_rep_evt) begin
      r_rep_cnt   <= CNT_W'(1);
      r_rep_first <= 1'b0;
    end else if (r_rep_cnt != '0) begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_evt = 1'b0;
`endif

  // Step presses count only while paused; an already pending request is
  // left alone if the run level changes underneath it.
  assign w_step_evt = (w_rise[2] & ~r_running) | w_rep_evt;

  // Command latches. A new event in the same cycle as an ack wins, so a
  // request is never lost; repeated events simply merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running <= 1'b1;
      r_upd_req <= 1'b0;
      r_rnd_req <= 1'b0;
    end else begin
      if (w_rise[0]) r_running <= ~r_running;

      if (w_rise[1])    r_rnd_req <= 1'b1;
      else if (rnd_ack) r_rnd_req <= 1'b0;

      if (w_step_evt)   r_upd_req <= 1'b1;
      else if (upd_ack) r_upd_req <= 1'b0;
    end
  end

  assign running   = r_running;
  assign upd_req   = r_upd_req;
  assign rnd_req   = r_rnd_req;
  assign btn_level = r_stable;

endmodule

// File: tb/tb_gol_input_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for gol_input_ctrl. A cycle-level behavioural model predicts the
// outputs after each clock edge and queues them; an independent monitor pops
// the queue on the falling edge and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_gol_input_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 8;
  localparam int RD  = 8;
  localparam int RP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_in = 3'b000;
  logic       upd_ack = 1'b0;
  logic       rnd_ack = 1'b0;
  logic       running;
  logic       upd_req;
  logic       rnd_req;
  logic [2:0] btn_level;

  always #5 clk = ~clk;

  gol_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .upd_ack  (upd_ack),
    .rnd_ack  (rnd_ack),
    .running  (running),
    .upd_req  (upd_req),
    .rnd_req  (rnd_req),
    .btn_level(btn_level)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_push   = 0;
  int n_pop    = 0;

  logic [5:0] exp_q[$];

  // Model state: raw input history plus the architectural outputs.
  logic [2:0] hist[$];
  int         k;
  logic [2:0] m_stable, m_stable_d;
  logic       m_run, m_upd, m_rnd;
  int         rep_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic samp(input int idx, input int b);
    logic [2:0] v;
    if (idx < 0) return 1'b0;
    v = hist[idx];
    return v[b];
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(3'b000);
    hist.push_back(3'b000);
    k          = 0;
    m_stable   = '0;
    m_stable_d = '0;
    m_run      = 1'b1;
    m_upd      = 1'b0;
    m_rnd      = 1'b0;
    rep_start  = -1;
  endtask

  // Advance the model across one rising edge. hist[i] holds the input
  // sampled at edge i-1; the synchronised copy used at edge k is the one
  // sampled two edges earlier, i.e. hist[k-1].
  task automatic model_step();
    logic [2:0] rise_p, nxt;
    logic       hold, rep_evt, step_evt, all_v;
    int         n;
    k++;
    hist.push_back(btn_in);
    rise_p = m_stable & ~m_stable_d;
    nxt    = m_stable;
    // A level is accepted once the last DEB synchronised samples all agree
    // on the new value.
    for (int b = 0; b < 3; b++) begin
      all_v = 1'b1;
      for (int i = k - DEB; i <= k - 1; i++)
        if (samp(i, b) == m_stable[b]) all_v = 1'b0;
      if (all_v) nxt[b] = ~m_stable[b];
    end
    rep_evt = 1'b0;
`ifdef GOL_INPUT_AUTOREPEAT_EN
    hold = m_stable[2] & ~m_run;
    if (!hold) rep_start = -1;
    else if (rise_p[2]) rep_start = k;
    else if (rep_start >= 0) begin
      n = k - rep_start;
      if (n == RD || (n > RD && ((n - RD) % RP) == 0)) rep_evt = 1'b1;
    end
`else
    hold = 1'b0;
    n    = 0;
`endif
    step_evt = (rise_p[2] & ~m_run) | rep_evt;
    if (rise_p[1]) m_rnd = 1'b1;
    else if (rnd_ack) m_rnd = 1'b0;
    if (step_evt) m_upd = 1'b1;
    else if (upd_ack) m_upd = 1'b0;
    if (rise_p[0]) m_run = ~m_run;
    m_stable_d = m_stable;
    m_stable   = nxt;
    exp_q.push_back({m_run, m_upd, m_rnd, m_stable});
    n_push++;
  endtask

  task automatic cycle(input logic [2:0] b, input logic ua, input logic ra);
    @(negedge clk);
    btn_in  = b;
    upd_ack = ua;
    rnd_ack = ra;
    @(posedge clk);
    model_step();
  endtask

  // Monitor: compares every predicted output vector once the DUT has settled.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_pop++;
        check("outputs{run,upd,rnd,lvl}", {26'd0, running, upd_req, rnd_req, btn_level}, {26'd0, e});
      end
    end
  end

  initial begin
    logic [2:0] b;
    int         len;

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_state", {26'd0, running, upd_req, rnd_req, btn_level}, 32'b100000);

    // Run toggle: long press, release, then a too-short glitch.
    repeat (10) cycle(3'b001, 1'b0, 1'b0);
    repeat (10) cycle(3'b000, 1'b0, 1'b0);
    repeat (3)  cycle(3'b001, 1'b0, 1'b0);
    repeat (10) cycle(3'b000, 1'b0, 1'b0);

    // Paused step press, ack withheld for a long time then pulsed once.
    repeat (8)  cycle(3'b100, 1'b0, 1'b0);
    repeat (22) cycle(3'b000, 1'b0, 1'b0);
    cycle(3'b000, 1'b1, 1'b0);
    repeat (3)  cycle(3'b000, 1'b0, 1'b0);

    // Back to running; a step press is now dropped.
    repeat (8)  cycle(3'b001, 1'b0, 1'b0);
    repeat (8)  cycle(3'b000, 1'b0, 1'b0);
    repeat (8)  cycle(3'b100, 1'b0, 1'b0);
    repeat (8)  cycle(3'b000, 1'b0, 1'b0);

    // Randomise twice; the second rise collides with an ack.
    repeat (8)  cycle(3'b010, 1'b0, 1'b0);
    repeat (8)  cycle(3'b000, 1'b0, 1'b0);
    repeat (8)  cycle(3'b010, 1'b0, m_stable[1] & ~m_stable_d[1]);
    repeat (8)  cycle(3'b000, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b1);
    repeat (3)  cycle(3'b000, 1'b0, 1'b0);

    // Run and randomise pressed together.
    repeat (8)  cycle(3'b011, 1'b0, 1'b0);
    repeat (8)  cycle(3'b000, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b1);
    repeat (3)  cycle(3'b000, 1'b0, 1'b0);

    // Paused, step held 30 cycles, each request acked one cycle later.
    for (int i = 0; i < 30; i++) cycle(3'b100, m_upd, 1'b0);
    for (int i = 0; i < 10; i++) cycle(3'b000, m_upd, 1'b0);

    // Randomised buttons held for random spans, random acks.
    for (int i = 0; i < 300; i++) begin
      b   = 3'($urandom);
      len = $urandom_range(1, 8);
      repeat (len) cycle(b, ($urandom % 4) == 0, ($urandom % 4) == 0);
    end

    // Asynchronous reset asserted mid-period.
    repeat (4) cycle(3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", {26'd0, running, upd_req, rnd_req, btn_level}, 32'b100000);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_reset", {26'd0, running, upd_req, rnd_req, btn_level}, 32'b100000);
    repeat (8)  cycle(3'b001, 1'b0, 1'b0);
    repeat (8)  cycle(3'b000, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("monitor_pop_count", 32'(n_pop), 32'(n_push));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
